// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI transmitter.
// Holds the frame FSM state type, the default word width and sclk divider,
// and a constant-friendly ceiling-log2 helper used to size counters.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_e;

  localparam int DEFAULT_DATA_W     = 16;
  localparam int DEFAULT_CLK_DIV    = 4;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with asynchronous active-high reset.
// Ports:
//   clk, reset        - clock and async reset (empties the FIFO)
//   push_i, wdata_i   - write request and data; ignored while full
//   pop_i, rdata_o    - read request and current head (show-ahead)
//   full_o, empty_o   - occupancy flags
//   level_o           - current occupancy, 0..DEPTH
module sample_fifo
  import dac_spi_pkg::*;
#(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [LW-1:0]    level_q;
  logic             pushEn;
  logic             popEn;

  // A full FIFO refuses a push even when a pop frees a slot in the same
  // cycle, so the ready seen upstream only ever depends on registered level.
  always_comb begin
    full_o  = (level_q == LW'(DEPTH));
    empty_o = (level_q == '0);
    pushEn  = push_i && !full_o;
    popEn   = pop_i && !empty_o;
    rdata_o = mem_q[rdPtr_q];
    level_o = level_q;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (pushEn) wrPtr_q <= wrPtr_q + 1'b1;
      if (popEn)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({pushEn, popEn})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serializes buffered samples onto an SPI mode-0 link to an external DAC.
// Ports:
//   clk, reset           - clock and async active-high reset
//   s_data/s_valid/s_ready - sample input handshake into the FIFO
//   dac_sclk/dac_mosi/dac_cs_n - SPI pins, sclk idles low, MSB first
//   busy                 - a frame is in LOAD, SHIFT or GAP
//   frame_done           - one-cycle pulse on the first GAP cycle
//   fifo_level           - current FIFO occupancy
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int  DATA_W        = DEFAULT_DATA_W,
  parameter int  CLK_DIV       = DEFAULT_CLK_DIV,
  parameter int  FIFO_DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int  OFFSET_BINARY = 1,
  localparam int LVL_W         = clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              dac_sclk,
  output logic              dac_mosi,
  output logic              dac_cs_n,
  output logic              busy,
  output logic              frame_done,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int DIV_W = clog2(CLK_DIV + 1);
  localparam int BIT_W = clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic             MSB_FLIP = (OFFSET_BINARY != 0);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  logic [DATA_W-1:0] fifoHead;
  logic [DATA_W-1:0] dacWord;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              push;
  logic              pop;
  logic              divEnd;

  assign s_ready = !fifoFull;
  assign push    = s_valid && s_ready;
  assign divEnd  = (div_q == DIV_LAST);
  // Offset-binary conversion is only an MSB flip; no arithmetic.
  assign dacWord = {fifoHead[DATA_W-1] ^ MSB_FLIP, fifoHead[DATA_W-2:0]};

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (s_data),
    .pop_i   (pop),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifo_level)
  );

  // State and datapath registers; reset forces the link idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state logic. The shift register MSB drives mosi directly, so
  // shifting at the end of a high half presents the next bit as sclk falls,
  // keeping mosi stable across the whole high phase.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) state_d = LOAD;
      end
      LOAD: begin
        shreg_d = dacWord;
        div_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (divEnd) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              shreg_d = '0;
              state_d = GAP;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (divEnd) begin
          div_d   = '0;
          state_d = fifoEmpty ? IDLE : LOAD;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; cs_n covers LOAD and SHIFT so it
  // falls one cycle before the shift phase begins.
  always_comb begin
    dac_cs_n   = !((state_q == LOAD) || (state_q == SHIFT));
    dac_sclk   = sclk_q;
    dac_mosi   = shreg_q[DATA_W-1];
    busy       = (state_q != IDLE);
    frame_done = (state_q == GAP) && (div_q == '0);
    pop        = (state_q == LOAD);
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed, scoreboard-based bench for dac_spi_tx: one default instance and
// one with CLK_DIV=1 and offset binary disabled.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sData = '0;
  logic        sValid = 1'b0;
  logic        s_ready, dac_sclk, dac_mosi, dac_cs_n, busy, frame_done;
  logic [2:0]  fifo_level;

  logic [15:0] sDataB = '0;
  logic        sValidB = 1'b0;
  logic        sReadyB, sclkB, mosiB, csNB, busyB, doneB;
  logic [2:0]  levelB;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] expQ[$];
  logic [15:0] expQB[$];
  int          gapQ[$];
  int          doneStamps[$];
  int          doneStampsB[$];

  int          framesSeen = 0, framesSeenB = 0;
  int          bitCnt = 0, bitCntB = 0;
  logic [15:0] shiftWord = '0, shiftWordB = '0;
  logic        sclkPrev = 1'b0, sclkPrevB = 1'b0;
  int          lowCnt = 0, highCnt = 0, lastLow = 0;
  int          cycle = 0, cycleB = 0;
  int          maxLevel = 0;

  always #5 clk = ~clk;

  dac_spi_tx dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (sData),
    .s_valid    (sValid),
    .s_ready    (s_ready),
    .dac_sclk   (dac_sclk),
    .dac_mosi   (dac_mosi),
    .dac_cs_n   (dac_cs_n),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_level (fifo_level)
  );

  dac_spi_tx #(.CLK_DIV(1), .OFFSET_BINARY(0)) dutB (
    .clk        (clk),
    .reset      (reset),
    .s_data     (sDataB),
    .s_valid    (sValidB),
    .s_ready    (sReadyB),
    .dac_sclk   (sclkB),
    .dac_mosi   (mosiB),
    .dac_cs_n   (csNB),
    .busy       (busyB),
    .frame_done (doneB),
    .fifo_level (levelB)
  );

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offers one sample to instance A (called at a negedge) and records the
  // expected DAC code; returns one negedge after the accepting clock edge
  // with s_valid still high so consecutive calls stream without gaps.
  task automatic applyStimulus(input logic [15:0] d);
    int guard;
    guard = 0;
    sData  = d;
    sValid = 1'b1;
    while (!s_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) checkOutput("push timeout", 0, 1);
    else expQ.push_back(d ^ 16'h8000);
    @(negedge clk);
  endtask

  task automatic waitDone(input string tag);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!frame_done && guard < 2000);
    checkOutput(tag, frame_done, 1);
  endtask

  task automatic waitFrames(input int target);
    int guard;
    guard = 0;
    while (framesSeen < target && guard < 4000) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("frame wait", framesSeen >= target, 1);
  endtask

  // Instance A monitor: captures mosi on sclk rises, measures cs_n timing
  // and pops the scoreboard on each frame_done.
  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      bitCnt = 0;
      shiftWord = '0;
      lowCnt = 0;
      highCnt = 0;
    end else begin
      checkOutput("s_ready", s_ready, fifo_level != 3'd4);
      if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
      if (dac_sclk && !sclkPrev) begin
        shiftWord = {shiftWord[14:0], dac_mosi};
        bitCnt++;
      end
      if (dac_cs_n) begin
        if (lowCnt > 0) begin
          lastLow = lowCnt;
          lowCnt = 0;
        end
        highCnt++;
      end else begin
        if (highCnt > 0) begin
          gapQ.push_back(highCnt);
          highCnt = 0;
        end
        lowCnt++;
      end
      if (frame_done) begin
        doneStamps.push_back(cycle);
        if (expQ.size() == 0) checkOutput("unexpected frame", 1, 0);
        else checkOutput("frame word", shiftWord, expQ.pop_front());
        checkOutput("frame bits", bitCnt, 16);
        bitCnt = 0;
        framesSeen++;
      end
    end
    sclkPrev = dac_sclk;
  end

  // Instance B monitor: same capture with its own scoreboard.
  always @(negedge clk) begin
    cycleB++;
    if (reset) begin
      bitCntB = 0;
      shiftWordB = '0;
    end else begin
      if (sclkB && !sclkPrevB) begin
        shiftWordB = {shiftWordB[14:0], mosiB};
        bitCntB++;
      end
      if (doneB) begin
        doneStampsB.push_back(cycleB);
        if (expQB.size() == 0) checkOutput("B unexpected frame", 1, 0);
        else checkOutput("B frame word", shiftWordB, expQB.pop_front());
        checkOutput("B frame bits", bitCntB, 16);
        bitCntB = 0;
        framesSeenB++;
      end
    end
    sclkPrevB = sclkB;
  end

  initial begin
    int base;
    int guard;
    int diff;

    // Reset held with s_valid high: link idle, nothing buffered.
    sValid = 1'b1;
    sData  = 16'h7777;
    repeat (3) @(negedge clk);
    checkOutput("reset cs_n", dac_cs_n, 1);
    checkOutput("reset sclk", dac_sclk, 0);
    checkOutput("reset mosi", dac_mosi, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset level", fifo_level, 0);
    checkOutput("reset s_ready", s_ready, 1);
    checkOutput("reset frame_done", frame_done, 0);
    sValid = 1'b0;
    reset  = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("idle cs_n", dac_cs_n, 1);
    checkOutput("idle busy", busy, 0);
    checkOutput("idle frames", framesSeen, 0);

    // Single zero sample: LOAD one cycle after the push lands.
    $display("[TB] single frame");
    applyStimulus(16'h0000);
    sValid = 1'b0;
    checkOutput("pre-load busy", busy, 0);
    checkOutput("pre-load level", fifo_level, 1);
    @(negedge clk);
    checkOutput("load cs_n", dac_cs_n, 0);
    checkOutput("load busy", busy, 1);
    waitDone("single frame_done");
    checkOutput("gap cs_n", dac_cs_n, 1);
    checkOutput("gap busy first", busy, 1);
    repeat (3) @(negedge clk);
    checkOutput("gap busy last", busy, 1);
    checkOutput("gap frame_done pulse", frame_done, 0);
    @(negedge clk);
    checkOutput("post-gap busy", busy, 0);
    checkOutput("cs_n low time", lastLow, 129);

    // Three back-to-back samples covering both extremes.
    $display("[TB] back-to-back frames");
    gapQ.delete();
    doneStamps.delete();
    base = framesSeen;
    applyStimulus(16'h8000);
    applyStimulus(16'h7FFF);
    applyStimulus(16'h1234);
    sValid = 1'b0;
    waitFrames(base + 3);
    repeat (10) @(negedge clk);
    checkOutput("b2b gap count", gapQ.size(), 3);
    if (gapQ.size() == 3) begin
      checkOutput("b2b gap 1", gapQ[1], 4);
      checkOutput("b2b gap 2", gapQ[2], 4);
    end
    diff = (doneStamps.size() == 3) ? doneStamps[2] - doneStamps[1] : -1;
    checkOutput("b2b frame period", diff, 133);
    checkOutput("b2b scoreboard empty", expQ.size(), 0);

    // Streaming 8 samples through a 4-deep buffer.
    $display("[TB] streaming");
    maxLevel = 0;
    base = framesSeen;
    for (int i = 0; i < 8; i++) applyStimulus(16'h0F1E + 16'(i * 16'h2345));
    sValid = 1'b0;
    waitFrames(base + 8);
    repeat (10) @(negedge clk);
    checkOutput("stream level drained", fifo_level, 0);
    checkOutput("stream max level", maxLevel, 4);
    checkOutput("stream scoreboard empty", expQ.size(), 0);

    // Reset in the middle of a frame with two samples queued.
    $display("[TB] reset mid-frame");
    base = framesSeen;
    applyStimulus(16'h1111);
    applyStimulus(16'h2222);
    applyStimulus(16'h3333);
    sValid = 1'b0;
    guard = 0;
    while (bitCnt < 7 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("mid-frame reach", bitCnt, 7);
    #1;
    checkOutput("mid-frame queued", fifo_level, 2);
    reset = 1'b1;
    #1;
    checkOutput("async reset cs_n", dac_cs_n, 1);
    checkOutput("async reset sclk", dac_sclk, 0);
    checkOutput("async reset level", fifo_level, 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(16'h00FF);
    sValid = 1'b0;
    waitFrames(base + 1);
    repeat (200) @(negedge clk);
    checkOutput("post-reset single frame", framesSeen, base + 1);
    checkOutput("post-reset scoreboard", expQ.size(), 0);

    // Fastest divider, codes passed through unchanged.
    $display("[TB] CLK_DIV=1 instance");
    sDataB  = 16'hA5A5;
    sValidB = 1'b1;
    expQB.push_back(16'hA5A5);
    expQB.push_back(16'hA5A5);
    repeat (2) @(negedge clk);
    sValidB = 1'b0;
    guard = 0;
    while (framesSeenB < 2 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("B frame wait", framesSeenB, 2);
    repeat (5) @(negedge clk);
    diff = (doneStampsB.size() == 2) ? doneStampsB[1] - doneStampsB[0] : -1;
    checkOutput("B frame period", diff, 34);
    checkOutput("B scoreboard empty", expQB.size(), 0);
    checkOutput("B idle cs_n", csNB, 1);
    checkOutput("B idle busy", busyB, 0);
    checkOutput("B level", levelB, 0);
    checkOutput("B s_ready", sReadyB, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
